// File: rtl/buzzer_seq.sv
// buzzer_seq: multi-tone square-wave buzzer for a single speaker pin.
// A table of NUM_TONES half-period divisors (0 = rest) is played in one of
// three ways: hold one selected entry, cycle through the table, or play the
// table once and stop. The speaker output and all status outputs are flops.
module buzzer_seq #(
  parameter int NUM_TONES = 4,
  parameter int DIV_W     = 24,
  parameter int STEP_W    = 26,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       onoff,
  input  logic [1:0]                 mode,
  input  logic [IDX_W-1:0]           tone_sel,
  input  logic [NUM_TONES*DIV_W-1:0] tone_div,
  input  logic [STEP_W-1:0]          step_len,
  output logic                       sp,
  output logic [IDX_W-1:0]           tone_idx,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  localparam logic [1:0]       MODE_HOLD    = 2'b00;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [1:0]       MODE_RSVD    = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_TONES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               sp_q, sp_d;
  logic               done_q, done_d;
  logic               busy_q;
  logic [1:0]         mode_q;

  logic [1:0]         mode_eff_s;
  logic [IDX_W-1:0]   sel_clamp_s;
  logic [DIV_W-1:0]   div_cur_s;
  logic [STEP_W-1:0]  step_last_s;
  logic [DIV_W-1:0]   div_cnt_s;
  logic               div_sp_s;
  logic               step_expired_s;
  logic [IDX_W-1:0]   idx_inc_s;

  // Out-of-range tone_sel values play the last table entry; when the index
  // width exactly covers the table no clamp is needed.
  if (NUM_TONES < (1 << IDX_W)) begin : g_clamp
    assign sel_clamp_s = (tone_sel > LAST_IDX) ? LAST_IDX : tone_sel;
  end else begin : g_noclamp
    assign sel_clamp_s = tone_sel;
  end

  // Decode mode, pick the active divisor and the last count of a step
  always_comb begin
    mode_eff_s     = (mode == MODE_RSVD) ? MODE_HOLD : mode;
    div_cur_s      = tone_div[int'(idx_q) * DIV_W +: DIV_W];
    step_last_s    = (step_len == '0) ? '0 : (step_len - STEP_W'(1));
    step_expired_s = (step_q >= step_last_s);
    idx_inc_s      = (idx_q == LAST_IDX) ? '0 : (idx_q + IDX_W'(1));
  end

  // Half-period divider for the current entry; a divisor that shrank below
  // the running count restarts the count without toggling the pin
  always_comb begin
    div_cnt_s = cnt_q;
    div_sp_s  = sp_q;
    if (div_cur_s == '0) begin
      div_cnt_s = '0;
      div_sp_s  = 1'b0;
    end else if (cnt_q == (div_cur_s - DIV_W'(1))) begin
      div_cnt_s = '0;
      div_sp_s  = ~sp_q;
    end else if (cnt_q >= div_cur_s) begin
      div_cnt_s = '0;
      div_sp_s  = sp_q;
    end else begin
      div_cnt_s = cnt_q + DIV_W'(1);
      div_sp_s  = sp_q;
    end
  end

  // Next-state and datapath decisions for the play sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sp_d    = sp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        step_d = '0;
        sp_d   = 1'b0;
        if (onoff) begin
          state_d = ST_PLAY;
          idx_d   = (mode_eff_s == MODE_HOLD) ? sel_clamp_s : '0;
        end else begin
          idx_d   = '0;
        end
      end
      ST_PLAY: begin
        if (!onoff) begin
          // Switching off beats every other event in the same cycle
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          step_d  = '0;
          sp_d    = 1'b0;
        end else if ((mode_eff_s == MODE_HOLD) && (sel_clamp_s != idx_q)) begin
          // New tone in hold mode (or entry into hold): restart phase-aligned low
          idx_d  = sel_clamp_s;
          cnt_d  = '0;
          step_d = '0;
          sp_d   = 1'b0;
        end else if ((mode_eff_s != mode_q) || (mode_eff_s == MODE_HOLD)) begin
          // Mode switch restarts the step timer; hold mode keeps it parked
          step_d = '0;
          cnt_d  = div_cnt_s;
          sp_d   = div_sp_s;
        end else if (step_expired_s) begin
          step_d = '0;
          cnt_d  = '0;
          sp_d   = 1'b0;
          if ((mode_eff_s == MODE_ONESHOT) && (idx_q == LAST_IDX)) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_inc_s;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
          cnt_d  = div_cnt_s;
          sp_d   = div_sp_s;
        end
      end
      ST_FINISH: begin
        cnt_d  = '0;
        step_d = '0;
        sp_d   = 1'b0;
        if (!onoff) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = LAST_IDX;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        step_d  = '0;
        sp_d    = 1'b0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, current index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      step_q <= '0;
      sp_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      sp_q   <= sp_d;
      done_q <= done_d;
      busy_q <= (state_d == ST_PLAY);
      mode_q <= mode_eff_s;
    end
  end

  assign sp       = sp_q;
  assign tone_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
